// File: rtl/pipeline_hazard_scoreboard.sv
// Combined forwarding and hazard-detection unit for the in-order MIPS pipeline.
// Keeps a shadow scoreboard of in-flight destinations (entry 0 = EX, entry k = k stages later)
// and derives forward selects, load-use/branch stalls, branch flush and memory freeze from it.
module pipeline_hazard_scoreboard #(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned FWD_STAGES = 2,
   parameter int unsigned LOAD_LAT   = 1,
   parameter int unsigned SEL_W      = 2,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_branch,
   input  logic              branch_taken,
   input  logic              mem_busy,
   output logic [SEL_W-1:0]  forward_a,
   output logic [SEL_W-1:0]  forward_b,
   output logic [SEL_W-1:0]  fwd_id_a,
   output logic [SEL_W-1:0]  fwd_id_b,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              bubble,
   output logic              if_id_flush,
   output logic              freeze,
   output logic [1:0]        hz_state,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {StRun = 2'd0, StStall = 2'd1, StFreeze = 2'd2} hz_state_e;

   hz_state_e                       state_q, state_d;
   logic [FWD_STAGES:0]             sb_v_q, sb_wr_q, sb_ld_q, sb_ready;
   logic [FWD_STAGES:0][REG_AW-1:0] sb_rd_q;
   logic [REG_AW-1:0]               ex_rs_q, ex_rt_q;
   logic                            ex_use_rs_q, ex_use_rt_q;
   logic [CNT_W-1:0]                stall_cnt_q;
   logic [FWD_STAGES:0]             m_ex_a, m_ex_b, m_id_a, m_id_b;
   logic                            stall;

   // Youngest match wins; a youngest match that is still an unfinished load gives 0.
   function automatic logic [SEL_W-1:0] ex_pick(input logic [FWD_STAGES:0] m,
                                                input logic [FWD_STAGES:0] rdy);
      logic [SEL_W-1:0] sel;
      sel = '0;
      for (int s = int'(FWD_STAGES); s >= 1; s--) begin
         if (m[s]) sel = rdy[s] ? SEL_W'(s) : '0;
      end
      return sel;
   endfunction

   // Youngest match that already holds its result.
   function automatic logic [SEL_W-1:0] id_pick(input logic [FWD_STAGES:0] m,
                                                input logic [FWD_STAGES:0] rdy);
      logic [SEL_W-1:0] sel;
      sel = '0;
      for (int s = int'(FWD_STAGES); s >= 1; s--) begin
         if (m[s] && rdy[s]) sel = SEL_W'(s);
      end
      return sel;
   endfunction

   // Hazard on one ID operand: load too young to forward, or branch needing an unresolved value.
   function automatic logic op_stall(input logic [FWD_STAGES:0] m,
                                     input logic [FWD_STAGES:0] ld,
                                     input logic                br);
      logic hit, found;
      hit   = 1'b0;
      found = 1'b0;
      for (int s = 0; s <= int'(FWD_STAGES); s++) begin
         if (m[s] && ld[s] && (s < int'(LOAD_LAT))) hit = 1'b1;
         if (br && m[s] && !found) begin
            found = 1'b1;
            if ((s == 0) || (ld[s] && (s <= int'(LOAD_LAT)))) hit = 1'b1;
         end
      end
      return hit;
   endfunction

   // Per-entry readiness and destination matches for the EX and ID operands.
   always_comb begin
      for (int s = 0; s <= int'(FWD_STAGES); s++) begin
         sb_ready[s] = !sb_ld_q[s] || (s > int'(LOAD_LAT));
         m_ex_a[s]   = sb_v_q[s] && sb_wr_q[s] && (sb_rd_q[s] == ex_rs_q) &&
                       (ex_rs_q != '0) && ex_use_rs_q;
         m_ex_b[s]   = sb_v_q[s] && sb_wr_q[s] && (sb_rd_q[s] == ex_rt_q) &&
                       (ex_rt_q != '0) && ex_use_rt_q;
         m_id_a[s]   = sb_v_q[s] && sb_wr_q[s] && (sb_rd_q[s] == id_rs) && (id_rs != '0);
         m_id_b[s]   = sb_v_q[s] && sb_wr_q[s] && (sb_rd_q[s] == id_rt) && (id_rt != '0);
      end
   end

   assign stall = id_valid &&
                  ((id_use_rs && op_stall(m_id_a, sb_ld_q, id_branch)) ||
                   (id_use_rt && op_stall(m_id_b, sb_ld_q, id_branch)));

   // Per-cycle decision: freeze beats stall beats run.
   always_comb begin
      state_d = StRun;
      if (mem_busy) begin
         state_d = StFreeze;
      end else if (stall) begin
         state_d = StStall;
      end
   end

   // Control outputs; held at run values while reset is asserted.
   always_comb begin
      freeze      = mem_busy;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      bubble      = 1'b0;
      if_id_flush = 1'b0;
      forward_a   = ex_pick(m_ex_a, sb_ready);
      forward_b   = ex_pick(m_ex_b, sb_ready);
      fwd_id_a    = id_branch ? id_pick(m_id_a, sb_ready) : '0;
      fwd_id_b    = id_branch ? id_pick(m_id_b, sb_ready) : '0;
      if (rst) begin
         unique case (state_d)
            StFreeze: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
            end
            StStall: begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               bubble      = 1'b1;
            end
            default: if_id_flush = id_valid && id_branch && branch_taken;
         endcase
      end
   end

   assign hz_state  = state_q;
   assign stall_cnt = stall_cnt_q;

   // Scoreboard shift, decision history and saturating stall counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StRun;
         sb_v_q      <= '0;
         sb_wr_q     <= '0;
         sb_ld_q     <= '0;
         sb_rd_q     <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_use_rs_q <= 1'b0;
         ex_use_rt_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if ((state_d != StRun) && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (state_d != StFreeze) begin
            // A stall shifts in an empty entry, which is the bubble entering EX.
            sb_v_q      <= {sb_v_q[FWD_STAGES-1:0], (state_d == StRun) && id_valid};
            sb_wr_q     <= {sb_wr_q[FWD_STAGES-1:0], id_reg_write};
            sb_ld_q     <= {sb_ld_q[FWD_STAGES-1:0], id_mem_read};
            sb_rd_q     <= {sb_rd_q[FWD_STAGES-1:0], id_rd};
            ex_rs_q     <= id_rs;
            ex_rt_q     <= id_rt;
            ex_use_rs_q <= (state_d == StRun) && id_valid && id_use_rs;
            ex_use_rt_q <= (state_d == StRun) && id_valid && id_use_rt;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: directed vector table, corner sequences,
// then random traffic against an instruction-queue reference model.
module tb_pipeline_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read;
   logic       id_branch, branch_taken, mem_busy;
   logic [4:0] id_rs, id_rt, id_rd;

   logic [1:0]  forward_a, forward_b, fwd_id_a, fwd_id_b, hz_state;
   logic        pc_write, if_id_write, bubble, if_id_flush, freeze;
   logic [15:0] stall_cnt;

   logic [1:0] forward_a2, forward_b2, fwd_id_a2, fwd_id_b2, hz_state2;
   logic       pc_write2, if_id_write2, bubble2, if_id_flush2, freeze2;
   logic [3:0] stall_cnt2;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipeline_hazard_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_branch(id_branch),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .forward_a(forward_a),
      .forward_b(forward_b), .fwd_id_a(fwd_id_a), .fwd_id_b(fwd_id_b), .pc_write(pc_write),
      .if_id_write(if_id_write), .bubble(bubble), .if_id_flush(if_id_flush), .freeze(freeze),
      .hz_state(hz_state), .stall_cnt(stall_cnt)
   );

   pipeline_hazard_scoreboard #(
      .REG_AW(5), .FWD_STAGES(3), .LOAD_LAT(2), .SEL_W(2), .CNT_W(4)
   ) dut2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_branch(id_branch),
      .branch_taken(branch_taken), .mem_busy(mem_busy), .forward_a(forward_a2),
      .forward_b(forward_b2), .fwd_id_a(fwd_id_a2), .fwd_id_b(fwd_id_b2),
      .pc_write(pc_write2), .if_id_write(if_id_write2), .bubble(bubble2),
      .if_id_flush(if_id_flush2), .freeze(freeze2), .hz_state(hz_state2),
      .stall_cnt(stall_cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int v, input int rs, input int rt, input int urs, input int urt,
                        input int rd, input int wr, input int ld, input int br, input int tk);
      id_valid     = 1'(v);
      id_rs        = 5'(rs);
      id_rt        = 5'(rt);
      id_use_rs    = 1'(urs);
      id_use_rt    = 1'(urt);
      id_rd        = 5'(rd);
      id_reg_write = 1'(wr);
      id_mem_read  = 1'(ld);
      id_branch    = 1'(br);
      branch_taken = 1'(tk);
   endtask

   task automatic idle();
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst      = 1'b0;
      mem_busy = 1'b0;
      idle();
      tick();
      tick();
      rst = 1'b1;
   endtask

   // ---------------- directed vector table (default parameters) ----------------
   typedef struct {
      int v, rs, rt, urs, urt, rd, wr, ld, br, tk;
      int fa, fb, fida, pcw, bub, fl, hz;
   } vec_t;
   vec_t tv [18];

   // ---------------- reference model: queue of in-flight instructions ----------------
   localparam int MF = 2;
   localparam int ML = 1;
   typedef struct {
      logic       v;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
   } inst_t;
   inst_t pipe [$];   // index = stages past ID, 0 = EX

   function automatic bit writes(input int s, input logic [4:0] r);
      return pipe[s].v && pipe[s].wr && (pipe[s].rd == r) && (r != 5'd0);
   endfunction

   // EX operand: nearest older producer; a producer whose load data is not back is illegal.
   function automatic int exp_ex(input logic [4:0] r, input logic used, output bit bad);
      int  res;
      bit  done;
      res  = 0;
      done = 0;
      bad  = 0;
      if (pipe[0].v && used) begin
         for (int s = 1; s <= MF; s++) begin
            if (!done && writes(s, r)) begin
               done = 1;
               if (pipe[s].ld && s <= ML) bad = 1;
               else res = s;
            end
         end
      end
      return res;
   endfunction

   function automatic int exp_id(input logic [4:0] r);
      int res;
      res = 0;
      for (int s = MF; s >= 1; s--) begin
         if (writes(s, r) && !(pipe[s].ld && s <= ML)) res = s;
      end
      return res;
   endfunction

   function automatic bit hazard(input logic [4:0] r, input logic br);
      int y;
      bit h;
      y = -1;
      h = 0;
      for (int s = 0; s <= MF; s++) begin
         if (writes(s, r)) begin
            if (pipe[s].ld && s < ML) h = 1;
            if (y < 0) y = s;
         end
      end
      if (br && y == 0) h = 1;
      if (br && y > 0 && pipe[y].ld && y <= ML) h = 1;
      return h;
   endfunction

   int    ea, eb, ia, ib, dec, m_cnt, m_hz;
   bit    bad_a, bad_b, stl, hold;
   inst_t nw;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, n_pass=%0d", n_pass);
      $fatal(1, "timeout");
   end

   initial begin
      //         v rs rt us ut rd wr ld br tk  fa fb fid pcw bub fl hz
      tv[0]  = '{1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[1]  = '{1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
      tv[3]  = '{1, 5, 6, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[5]  = '{1, 3, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0};
      tv[7]  = '{1, 1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[8]  = '{1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[10] = '{1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[11] = '{1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
      tv[12] = '{1, 2, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
      tv[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0};
      tv[14] = '{1, 1, 1, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      tv[15] = '{1, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0};
      tv[16] = '{1, 5, 0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1};
      tv[17] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0, 0, 0};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         issue(tv[i].v, tv[i].rs, tv[i].rt, tv[i].urs, tv[i].urt, tv[i].rd, tv[i].wr,
               tv[i].ld, tv[i].br, tv[i].tk);
         #2;
         chk($sformatf("tv%0d forward_a", i), 32'(forward_a), tv[i].fa);
         chk($sformatf("tv%0d forward_b", i), 32'(forward_b), tv[i].fb);
         chk($sformatf("tv%0d fwd_id_a", i), 32'(fwd_id_a), tv[i].fida);
         chk($sformatf("tv%0d pc_write", i), 32'(pc_write), tv[i].pcw);
         chk($sformatf("tv%0d if_id_write", i), 32'(if_id_write), tv[i].pcw);
         chk($sformatf("tv%0d bubble", i), 32'(bubble), tv[i].bub);
         chk($sformatf("tv%0d if_id_flush", i), 32'(if_id_flush), tv[i].fl);
         chk($sformatf("tv%0d hz_state", i), 32'(hz_state), tv[i].hz);
         tick();
      end
      #2;
      chk("tv stall_cnt", 32'(stall_cnt), 2);

      // Load latency 2, four tracked stages: two bubbles, then forward from stage 3.
      do_reset();
      issue(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      #2; chk("lat2 c0 bubble", 32'(bubble2), 0);
      tick();
      issue(1, 2, 3, 1, 1, 4, 1, 0, 0, 0);
      #2; chk("lat2 c1 bubble", 32'(bubble2), 1); chk("lat2 c1 pc_write", 32'(pc_write2), 0);
      tick();
      #2; chk("lat2 c2 bubble", 32'(bubble2), 1);
      tick();
      #2; chk("lat2 c3 bubble", 32'(bubble2), 0); chk("lat2 c3 pc_write", 32'(pc_write2), 1);
      tick();
      idle();
      #2; chk("lat2 forward_a", 32'(forward_a2), 3); chk("lat2 forward_b", 32'(forward_b2), 0);
      chk("lat2 stall_cnt", 32'(stall_cnt2), 2);
      tick();

      // Freeze for three cycles over a load-use stall, then exactly one bubble.
      do_reset();
      issue(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      tick();
      issue(1, 2, 3, 1, 1, 4, 1, 0, 0, 0);
      mem_busy = 1'b1;
      #2; chk("frz freeze", 32'(freeze), 1); chk("frz pc_write", 32'(pc_write), 0);
      chk("frz if_id_write", 32'(if_id_write), 0); chk("frz bubble", 32'(bubble), 0);
      tick();
      #2; chk("frz hz_state", 32'(hz_state), 2);
      tick();
      tick();
      mem_busy = 1'b0;
      #2; chk("frz release bubble", 32'(bubble), 1); chk("frz release freeze", 32'(freeze), 0);
      tick();
      #2; chk("frz after bubble", 32'(bubble), 0); chk("frz after pc_write", 32'(pc_write), 1);
      chk("frz stall_cnt", 32'(stall_cnt), 4); chk("frz hz stall", 32'(hz_state), 1);
      tick();
      idle();
      #2; chk("frz forward_a", 32'(forward_a), 2);
      tick();

      // Reset asserted in the middle of a stall.
      do_reset();
      issue(1, 1, 0, 1, 0, 2, 1, 1, 0, 0);
      mem_busy = 1'b1;
      tick();
      mem_busy = 1'b0;
      tick();
      issue(1, 2, 3, 1, 1, 4, 1, 0, 0, 0);
      #2; chk("rst pre bubble", 32'(bubble), 1); chk("rst pre stall_cnt", 32'(stall_cnt), 1);
      #1; rst = 1'b0; mem_busy = 1'b1;
      #1; chk("rst pc_write", 32'(pc_write), 1); chk("rst bubble", 32'(bubble), 0);
      chk("rst if_id_write", 32'(if_id_write), 1); chk("rst stall_cnt", 32'(stall_cnt), 0);
      chk("rst freeze", 32'(freeze), 1); chk("rst hz_state", 32'(hz_state), 0);
      mem_busy = 1'b0;
      tick();
      rst = 1'b1;
      #2; chk("rst cleared bubble", 32'(bubble), 0); chk("rst cleared pc_write", 32'(pc_write), 1);
      tick();

      // Counter saturation on the 4-bit instance while the wide one keeps counting.
      do_reset();
      mem_busy = 1'b1;
      repeat (18) tick();
      mem_busy = 1'b0;
      #2; chk("sat stall_cnt2", 32'(stall_cnt2), 15); chk("sat stall_cnt", 32'(stall_cnt), 18);
      chk("sat hz_state2", 32'(hz_state2), 2);
      tick();

      // Random traffic against the reference model.
      do_reset();
      nw = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0, rs: 5'd0, rt: 5'd0, urs: 1'b0, urt: 1'b0};
      pipe.delete();
      for (int s = 0; s <= MF; s++) pipe.push_back(nw);
      m_cnt = 0;
      m_hz  = 0;
      hold  = 0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            id_valid     = ($urandom_range(0, 4) != 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            id_use_rs    = ($urandom_range(0, 3) != 0);
            id_use_rt    = ($urandom_range(0, 1) != 0);
            id_rd        = 5'($urandom_range(0, 3));
            id_branch    = ($urandom_range(0, 3) == 0);
            branch_taken = ($urandom_range(0, 1) != 0);
            id_mem_read  = !id_branch && ($urandom_range(0, 2) == 0);
            id_reg_write = !id_branch && ($urandom_range(0, 4) != 0);
         end
         mem_busy = ($urandom_range(0, 7) == 0);
         #2;
         ea  = exp_ex(pipe[0].rs, pipe[0].urs, bad_a);
         eb  = exp_ex(pipe[0].rt, pipe[0].urt, bad_b);
         ia  = id_branch ? exp_id(id_rs) : 0;
         ib  = id_branch ? exp_id(id_rt) : 0;
         stl = id_valid && ((id_use_rs && hazard(id_rs, id_branch)) ||
                            (id_use_rt && hazard(id_rt, id_branch)));
         dec = mem_busy ? 2 : (stl ? 1 : 0);
         chk($sformatf("rnd%0d legal ex forward", c), 32'(bad_a || bad_b), 0);
         chk($sformatf("rnd%0d forward_a", c), 32'(forward_a), ea);
         chk($sformatf("rnd%0d forward_b", c), 32'(forward_b), eb);
         chk($sformatf("rnd%0d fwd_id_a", c), 32'(fwd_id_a), ia);
         chk($sformatf("rnd%0d fwd_id_b", c), 32'(fwd_id_b), ib);
         chk($sformatf("rnd%0d pc_write", c), 32'(pc_write), 32'(dec == 0));
         chk($sformatf("rnd%0d if_id_write", c), 32'(if_id_write), 32'(dec == 0));
         chk($sformatf("rnd%0d bubble", c), 32'(bubble), 32'(dec == 1));
         chk($sformatf("rnd%0d if_id_flush", c), 32'(if_id_flush),
             32'(dec == 0 && id_valid && id_branch && branch_taken));
         chk($sformatf("rnd%0d freeze", c), 32'(freeze), 32'(mem_busy));
         chk($sformatf("rnd%0d hz_state", c), 32'(hz_state), m_hz);
         chk($sformatf("rnd%0d stall_cnt", c), 32'(stall_cnt), m_cnt);
         if (dec != 2) begin
            nw.v   = (dec == 0) && id_valid;
            nw.rd  = id_rd;
            nw.wr  = id_reg_write;
            nw.ld  = id_mem_read;
            nw.rs  = id_rs;
            nw.rt  = id_rt;
            nw.urs = id_use_rs;
            nw.urt = id_use_rt;
            pipe.push_front(nw);
            void'(pipe.pop_back());
         end
         if (dec != 0 && m_cnt < 65535) m_cnt++;
         m_hz = dec;
         hold = (dec != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
